// File: rtl/tmds_encoder_rgb.sv
// Three-channel DVI/TMDS 8b/10b encoder, pixel clock domain, two-stage pipeline.
// Define TMDS_OUT_REG_EN to add a third register on tmds_r/g/b (latency 3).

module tmds_channel (
    input  logic       clk_pix,
    input  logic       rst_n_pix,
    input  logic [7:0] data_in,
    input  logic       de_in,
    input  logic [1:0] ctrl_in,
    output logic [9:0] tmds_out
);
    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    logic [3:0]        n1d;
    logic              use_xnor;
    logic [8:0]        q_m_d, q_m_q;
    logic              de_d, de_q;
    logic [1:0]        ctrl_d, ctrl_q;

    logic [3:0]        n1q, n0q;
    logic signed [5:0] cnt_ext, diff, cnt_next;
    logic signed [4:0] cnt_d, cnt_q;
    logic [9:0]        tmds_d, tmds_q;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    always_comb begin
        n1d      = popcount8(data_in);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_in[0]);
        q_m_d    = 9'd0;
        q_m_d[0] = data_in[0];
        for (int i = 1; i < 8; i++) begin
            q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data_in[i]) : (q_m_d[i-1] ^ data_in[i]);
        end
        q_m_d[8] = ~use_xnor;
        de_d     = de_in;
        ctrl_d   = ctrl_in;
    end

    // DC balance: choose inversion from the running disparity left by the previous cycle.
    always_comb begin
        n1q      = popcount8(q_m_q[7:0]);
        n0q      = 4'd8 - n1q;
        cnt_ext  = {cnt_q[4], cnt_q};
        diff     = $signed({2'b00, n1q}) - $signed({2'b00, n0q});
        tmds_d   = CTRL_00;
        cnt_next = 6'sd0;
        if (!de_q) begin
            case (ctrl_q)
                2'b00:   tmds_d = CTRL_00;
                2'b01:   tmds_d = CTRL_01;
                2'b10:   tmds_d = CTRL_10;
                default: tmds_d = CTRL_11;
            endcase
            cnt_next = 6'sd0;
        end else if ((cnt_q == 5'sd0) || (n1q == n0q)) begin
            tmds_d   = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
            cnt_next = q_m_q[8] ? (cnt_ext + diff) : (cnt_ext - diff);
        end else if (((cnt_q > 5'sd0) && (n1q > n0q)) || ((cnt_q < 5'sd0) && (n0q > n1q))) begin
            tmds_d   = {1'b1, q_m_q[8], ~q_m_q[7:0]};
            cnt_next = cnt_ext - diff + (q_m_q[8] ? 6'sd2 : 6'sd0);
        end else begin
            tmds_d   = {1'b0, q_m_q[8], q_m_q[7:0]};
            cnt_next = cnt_ext + diff - (q_m_q[8] ? 6'sd0 : 6'sd2);
        end
        cnt_d = cnt_next[4:0];
    end

    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            q_m_q  <= 9'd0;
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
            tmds_q <= CTRL_00;
            cnt_q  <= 5'sd0;
        end else begin
            q_m_q  <= q_m_d;
            de_q   <= de_d;
            ctrl_q <= ctrl_d;
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef TMDS_OUT_REG_EN
    logic [9:0] out_d, out_q;

    always_comb begin
        out_d = tmds_q;
    end

    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            out_q <= CTRL_00;
        end else begin
            out_q <= out_d;
        end
    end

    assign tmds_out = out_q;
`else
    assign tmds_out = tmds_q;
`endif

endmodule

module tmds_encoder_rgb #(
    parameter logic INVERT_SYNC = 1'b0
) (
    input  logic       clk_pix,
    input  logic       rst_n_pix,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] tmds_r,
    output logic [9:0] tmds_g,
    output logic [9:0] tmds_b
);
    logic hsync_enc;
    logic vsync_enc;

    // Only the blue channel carries sync; green and red always send ctrl 00 in blanking.
    assign hsync_enc = hsync ^ INVERT_SYNC;
    assign vsync_enc = vsync ^ INVERT_SYNC;

    tmds_channel u_chan_b (
        .clk_pix   (clk_pix),
        .rst_n_pix (rst_n_pix),
        .data_in   (b),
        .de_in     (de),
        .ctrl_in   ({vsync_enc, hsync_enc}),
        .tmds_out  (tmds_b)
    );

    tmds_channel u_chan_g (
        .clk_pix   (clk_pix),
        .rst_n_pix (rst_n_pix),
        .data_in   (g),
        .de_in     (de),
        .ctrl_in   (2'b00),
        .tmds_out  (tmds_g)
    );

    tmds_channel u_chan_r (
        .clk_pix   (clk_pix),
        .rst_n_pix (rst_n_pix),
        .data_in   (r),
        .de_in     (de),
        .ctrl_in   (2'b00),
        .tmds_out  (tmds_r)
    );

endmodule

// File: tb/tb_tmds_encoder_rgb.sv
// Self-checking bench for tmds_encoder_rgb: spec-level reference model plus literal expectations.
// Two instances run side by side, the second with INVERT_SYNC=1.

module tb_tmds_encoder_rgb;

`ifdef TMDS_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    localparam logic [9:0] CTRL_EXP [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    logic       clk_pix = 1'b0;
    logic       rst_n_pix;
    logic [7:0] r, g, b;
    logic       de, hsync, vsync;
    logic [9:0] tmds_r, tmds_g, tmds_b;
    logic [9:0] tmds_r_inv, tmds_g_inv, tmds_b_inv;

    typedef struct {
        logic [7:0] r, g, b;
        logic       de, hs, vs;
    } pix_t;

    typedef struct {
        int         due;
        int         ch;
        logic [9:0] val;
    } lit_t;

    pix_t pix_q[$];
    lit_t lit_q[$];
    int   m_cnt[3];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    tmds_encoder_rgb dut (
        .clk_pix   (clk_pix),
        .rst_n_pix (rst_n_pix),
        .r         (r),
        .g         (g),
        .b         (b),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync),
        .tmds_r    (tmds_r),
        .tmds_g    (tmds_g),
        .tmds_b    (tmds_b)
    );

    tmds_encoder_rgb #(.INVERT_SYNC(1'b1)) dut_inv (
        .clk_pix   (clk_pix),
        .rst_n_pix (rst_n_pix),
        .r         (r),
        .g         (g),
        .b         (b),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync),
        .tmds_r    (tmds_r_inv),
        .tmds_g    (tmds_g_inv),
        .tmds_b    (tmds_b_inv)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one pixel-clock worth of inputs just after the rising edge.
    task automatic applyStimulus(input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv,
                                 input logic dev, input logic hsv, input logic vsv);
        @(posedge clk_pix);
        #1;
        r = rv; g = gv; b = bv; de = dev; hsync = hsv; vsync = vsv;
    endtask

    // Literal expectation for the pixel just driven; ch 0=b 1=g 2=r 3=b(inverted sync instance).
    task automatic expectLit(input int ch, input logic [9:0] val);
        lit_t l;
        l.due = cyc + LAT;
        l.ch  = ch;
        l.val = val;
        lit_q.push_back(l);
    endtask

    // TMDS encoding written straight from the rules: transition minimisation then DC balance.
    function automatic void encode(input logic [7:0] d, input int cin,
                                   output logic [9:0] sym, output int cout);
        int         n1, n1q, n0q;
        logic       xn;
        logic [8:0] qm;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~xn;
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (cin == 0 || n1q == n0q) begin
            sym  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cout = cin + (qm[8] ? (n1q - n0q) : (n0q - n1q));
        end else if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
            sym  = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            sym  = {1'b0, qm[8], qm[7:0]};
            cout = cin + n1q - n0q - (qm[8] ? 0 : 2);
        end
    endfunction

    // Every post-reset rising edge feeds one input sample into the model's latency queue.
    always @(posedge clk_pix) begin
        cyc <= cyc + 1;
        if (rst_n_pix === 1'b1) begin
            pix_q.push_back('{r: r, g: g, b: b, de: de, hs: hsync, vs: vsync});
        end
    end

    // Compare the DUT against the model on every falling edge, then drain due literal checks.
    always @(negedge clk_pix) begin
        pix_t       p;
        logic [9:0] exp_r, exp_g, exp_b, exp_bi;
        int         ci;
        lit_t       l;
        if (rst_n_pix !== 1'b1) begin
            pix_q.delete();
            m_cnt = '{0, 0, 0};
            checkOutput("rst_b", tmds_b, 10'h354);
            checkOutput("rst_g", tmds_g, 10'h354);
            checkOutput("rst_r", tmds_r, 10'h354);
            checkOutput("rst_b_inv", tmds_b_inv, 10'h354);
        end else begin
            exp_r = 10'h354; exp_g = 10'h354; exp_b = 10'h354; exp_bi = 10'h354;
            if (pix_q.size() >= LAT) begin
                p = pix_q.pop_front();
                if (p.de) begin
                    encode(p.b, m_cnt[0], exp_b, m_cnt[0]);
                    encode(p.g, m_cnt[1], exp_g, m_cnt[1]);
                    encode(p.r, m_cnt[2], exp_r, m_cnt[2]);
                    exp_bi = exp_b;
                end else begin
                    ci     = {30'd0, p.vs, p.hs};
                    exp_b  = CTRL_EXP[ci];
                    exp_bi = CTRL_EXP[3 - ci];
                    m_cnt  = '{0, 0, 0};
                end
            end else begin
                m_cnt = '{0, 0, 0};
            end
            checkOutput("model_b", tmds_b, exp_b);
            checkOutput("model_g", tmds_g, exp_g);
            checkOutput("model_r", tmds_r, exp_r);
            checkOutput("model_b_inv", tmds_b_inv, exp_bi);
            checkOutput("model_g_inv", tmds_g_inv, exp_g);
            checkOutput("model_r_inv", tmds_r_inv, exp_r);
`ifndef TMDS_OUT_REG_EN
            checkCount("cnt_b", int'(dut.u_chan_b.cnt_q), m_cnt[0]);
            checkCount("cnt_g", int'(dut.u_chan_g.cnt_q), m_cnt[1]);
            checkCount("cnt_r", int'(dut.u_chan_r.cnt_q), m_cnt[2]);
`endif
        end
        while (lit_q.size() > 0 && lit_q[0].due <= cyc) begin
            l = lit_q.pop_front();
            case (l.ch)
                0:       checkOutput("lit_b", tmds_b, l.val);
                1:       checkOutput("lit_g", tmds_g, l.val);
                2:       checkOutput("lit_r", tmds_r, l.val);
                default: checkOutput("lit_b_inv", tmds_b_inv, l.val);
            endcase
        end
    end

    initial begin
        logic [9:0] b3_exp [3];
        b3_exp = '{10'h100, 10'h3FF, 10'h100};

        rst_n_pix = 1'b0;
        r = 8'h00; g = 8'h00; b = 8'h00; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
        repeat (3) @(posedge clk_pix);
        #1;
        rst_n_pix = 1'b1;
        $display("[TB] reset released");

        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
            expectLit(0, 10'h354);
            expectLit(1, 10'h354);
            expectLit(2, 10'h354);
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, i[0], i[1]);
            expectLit(0, CTRL_EXP[i]);
            expectLit(3, CTRL_EXP[3 - i]);
            expectLit(1, 10'h354);
            expectLit(2, 10'h354);
        end
        applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
            expectLit(0, b3_exp[i]);
            expectLit(1, b3_exp[i]);
            expectLit(2, b3_exp[i]);
        end
        applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        expectLit(1, 10'h200);
        expectLit(0, 10'h100);
        applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h5A, 8'hC3, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        #2;
        rst_n_pix = 1'b0;
        #1;
        checkOutput("midrst_b", tmds_b, 10'h354);
        checkOutput("midrst_g", tmds_g, 10'h354);
        checkOutput("midrst_r", tmds_r, 10'h354);
        repeat (2) @(posedge clk_pix);
        #1;
        rst_n_pix = 1'b1;
        r = 8'h00; g = 8'h00; b = 8'h00; de = 1'b1; hsync = 1'b0; vsync = 1'b0;
        expectLit(0, 10'h100);
        expectLit(1, 10'h100);
        applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        repeat (LAT + 3) applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        if (lit_q.size() != 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL lit_pending: got %0d unchecked, expected 0", lit_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
